// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_access_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mau_state_e;

   localparam logic [31:0] BUBBLE_DATA     = 32'h0;
   localparam int          TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts WAIT cycles without an acknowledge; hit flags the last allowed cycle.
module mem_timeout_cnt
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic en,
   output logic hit
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: issues loads/stores over a req/ack port, stalls the
// front of the pipeline while waiting, and drives the MEM/WB register.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] ALUres_i,
   input  logic [31:0] RS2data_i,
   input  logic [4:0]  RDaddr_i,
   input  logic        RegWrite_i,
   input  logic        MemtoReg_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic [31:0] ALUres_o,
   output logic [31:0] MEMdata_o,
   output logic [4:0]  RDaddr_o,
   output logic        RegWrite_o,
   output logic        MemtoReg_o,
   output logic        error_o
);

   mau_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;

   logic [31:0] alu_res_q, alu_res_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic        reg_write_q, reg_write_d;
   logic        mem_to_reg_q, mem_to_reg_d;
   logic        error_q, error_d;

   logic access;
   logic cnt_clear;
   logic cnt_en;
   logic cnt_hit;
   logic timeout_hit;
   logic stall;

   assign access = MemRead_i | MemWrite_i;

   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clear (cnt_clear),
      .en    (cnt_en),
      .hit   (cnt_hit)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      alu_res_d    = BUBBLE_DATA;
      mem_data_d   = BUBBLE_DATA;
      rd_addr_d    = '0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      error_d      = error_q;
      stall        = 1'b0;
      cnt_clear    = 1'b0;
      cnt_en       = 1'b0;
      timeout_hit  = 1'b0;

      case (state_q)
         IDLE: begin
            if (access) begin
               // A store wins when both control bits are set.
               stall     = 1'b1;
               addr_d    = ALUres_i;
               wdata_d   = RS2data_i;
               we_d      = MemWrite_i;
               cnt_clear = 1'b1;
               state_d   = WAIT;
            end else begin
               alu_res_d    = ALUres_i;
               rd_addr_d    = RDaddr_i;
               reg_write_d  = RegWrite_i;
               mem_to_reg_d = MemtoReg_i;
            end
         end
         WAIT: begin
            timeout_hit = cnt_hit & ~mem_ack_i;
            stall       = ~mem_ack_i & ~timeout_hit;
            cnt_en      = ~mem_ack_i;
            if (mem_ack_i || timeout_hit) begin
               // EX/MEM is still frozen here, so its fields describe this access.
               alu_res_d    = ALUres_i;
               rd_addr_d    = RDaddr_i;
               reg_write_d  = RegWrite_i & ~timeout_hit;
               mem_to_reg_d = MemtoReg_i;
               mem_data_d   = (mem_ack_i && !we_q) ? mem_rdata_i : BUBBLE_DATA;
               if (timeout_hit) begin
                  error_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         alu_res_q    <= '0;
         mem_data_q   <= '0;
         rd_addr_q    <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         alu_res_q    <= alu_res_d;
         mem_data_q   <= mem_data_d;
         rd_addr_q    <= rd_addr_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         error_q      <= error_d;
      end
   end

   assign mem_req_o   = (state_q == WAIT);
   assign mem_we_o    = mem_req_o & we_q;
   assign mem_addr_o  = mem_req_o ? addr_q : 32'h0;
   assign mem_wdata_o = mem_req_o ? wdata_q : 32'h0;
   assign stall_o     = stall;

   assign ALUres_o   = alu_res_q;
   assign MEMdata_o  = mem_data_q;
   assign RDaddr_o   = rd_addr_q;
   assign RegWrite_o = reg_write_q;
   assign MemtoReg_o = mem_to_reg_q;
   assign error_o    = error_q;

endmodule
